// File: rtl/pwm_ramp_sequencer_pkg.sv
// Shared types, default widths and duty-step helpers for the PWM ramp sequencer.
// Optional triangle mode is enabled by defining PWM_RAMP_TRIANGLE_EN.
package pwm_ramp_pkg;

  localparam int DUTY_W_DEF  = 8;
  localparam int PRESC_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } ramp_state_e;

  // One upward step: the sum is formed wide enough that it cannot wrap, then
  // clamped to the target. A zero step means "jump straight to the target".
  function automatic logic [31:0] sat_step_up(input logic [31:0] cur,
                                              input logic [31:0] step,
                                              input logic [31:0] tgt);
    logic [31:0] sum;
    if (step == 32'd0) return tgt;
    sum = cur + step;
    return (sum > tgt) ? tgt : sum;
  endfunction

  // One downward step: the difference floors at zero, then clamps to the target.
  function automatic logic [31:0] sat_step_down(input logic [31:0] cur,
                                                input logic [31:0] step,
                                                input logic [31:0] tgt);
    logic [31:0] diff;
    if (step == 32'd0) return tgt;
    diff = (cur < step) ? 32'd0 : cur - step;
    return (diff < tgt) ? tgt : diff;
  endfunction

endpackage

// File: rtl/pwm_ramp_sequencer_if.sv
// Register-bank side bundle of the PWM ramp sequencer: configuration in,
// applied duty and status out.
interface pwm_ramp_sequencer_if #(
  parameter int DUTY_W  = pwm_ramp_pkg::DUTY_W_DEF,
  parameter int PRESC_W = pwm_ramp_pkg::PRESC_W_DEF
);
  logic               ramp_en;
  logic [DUTY_W-1:0]  target_duty;
  logic [DUTY_W-1:0]  step_size;
  logic [PRESC_W-1:0] rate_div;
  logic               tri_mode;
  logic [DUTY_W-1:0]  duty_out;
  logic               busy;
  logic               done_pulse;

  // Register bank / test side
  modport master (
    output ramp_en, target_duty, step_size, rate_div, tri_mode,
    input  duty_out, busy, done_pulse
  );

  // Sequencer side
  modport slave (
    input  ramp_en, target_duty, step_size, rate_div, tri_mode,
    output duty_out, busy, done_pulse
  );
endinterface

// File: rtl/pwm_ramp_prescaler.sv
// Step-rate prescaler: counts clk cycles and raises tick once the count has
// reached rate_div, giving one tick every rate_div+1 cycles. The >= compare
// lets a lowered rate_div take effect on the very next cycle.
module pwm_ramp_prescaler #(
  parameter int PRESC_W = pwm_ramp_pkg::PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [PRESC_W-1:0] rate_div,
  output logic               tick
);

  logic [PRESC_W-1:0] count_q;

  assign tick = (count_q >= rate_div);

  // Cycle counter: cleared on request, wraps to zero on each tick.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr || tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// PWM duty ramp sequencer: moves the applied duty toward the requested target
// in step_size increments, one step every rate_div+1 cycles, with bypass when
// ramp_en is low. Define PWM_RAMP_TRIANGLE_EN to enable continuous
// target<->0 triangle sweeping under tri_mode.
module pwm_ramp_sequencer
  import pwm_ramp_pkg::*;
#(
  parameter int DUTY_W  = DUTY_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  pwm_ramp_sequencer_if.slave bus
);

  ramp_state_e       state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              busy_q;
  logic              done_q, done_d;
  logic              tick;
  logic              presc_clr;
  logic [DUTY_W-1:0] down_tgt;
  logic              tri_dn_q, tri_dn_d;  // DOWN leg of a triangle heads for 0

`ifdef PWM_RAMP_TRIANGLE_EN
  logic tri_req;
  assign tri_req = bus.tri_mode;
`else
  logic unused_tri_mode;
  logic tri_req;
  assign unused_tri_mode = bus.tri_mode;
  assign tri_req         = 1'b0;
`endif

  assign down_tgt = tri_dn_q ? '0 : bus.target_duty;

  // Prescaler restarts whenever we sit in IDLE or the state is about to change.
  assign presc_clr = (state_q == IDLE) || (state_d != state_q);

  pwm_ramp_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (presc_clr),
    .rate_div (bus.rate_div),
    .tick     (tick)
  );

  // Next-state, next-duty and arrival-pulse decisions.
  // NOTE: every always_comb output is defaulted first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    done_d   = 1'b0;
    tri_dn_d = tri_dn_q;

    if (!bus.ramp_en) begin
      duty_d   = bus.target_duty;
      state_d  = IDLE;
      tri_dn_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          tri_dn_d = 1'b0;
          if (bus.target_duty > duty_q)      state_d = UP;
          else if (bus.target_duty < duty_q) state_d = DOWN;
        end
        UP: begin
          if (bus.target_duty < duty_q) begin
            state_d = DOWN;
          end else if (bus.target_duty == duty_q) begin
            state_d = IDLE;
          end else if (tick) begin
            // NOTE: duty_d is blocking-assigned here, so the arrival test below sees the new value.
            duty_d = DUTY_W'(sat_step_up(32'(duty_q), 32'(bus.step_size),
                                         32'(bus.target_duty)));
            if (duty_d == bus.target_duty) begin
              done_d = 1'b1;
              if (tri_req) begin
                state_d  = DOWN;
                tri_dn_d = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        DOWN: begin
          if (down_tgt > duty_q) begin
            state_d  = UP;
            tri_dn_d = 1'b0;
          end else if (down_tgt == duty_q) begin
            state_d  = IDLE;
            tri_dn_d = 1'b0;
          end else if (tick) begin
            duty_d = DUTY_W'(sat_step_down(32'(duty_q), 32'(bus.step_size),
                                           32'(down_tgt)));
            if (duty_d == down_tgt) begin
              done_d   = 1'b1;
              tri_dn_d = 1'b0;
              if (tri_dn_q && tri_req && (bus.target_duty != '0)) state_d = UP;
              else                                                state_d = IDLE;
            end
          end
        end
        default: begin
          state_d  = IDLE;
          tri_dn_d = 1'b0;
        end
      endcase
    end
  end

  // Registered state and outputs; busy is derived from the next state so it
  // always matches the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tri_dn_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= done_d;
      tri_dn_q <= tri_dn_d;
    end
  end

  assign bus.duty_out   = duty_q;
  assign bus.busy       = busy_q;
  assign bus.done_pulse = done_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench for pwm_ramp_sequencer: directed vector table, hand
// sequences for reversal/abort/reset, and a randomized run against a
// behavioural model of the ramp rules.
module tb_pwm_ramp_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  pwm_ramp_sequencer_if #(.DUTY_W(8), .PRESC_W(16)) bus ();

  pwm_ramp_sequencer #(.DUTY_W(8), .PRESC_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en;
    int   tgt;
    int   step;
    int   rate;
    int   ncyc;
    int   duty;
    logic busy;
    logic done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input int tgt, input int step, input int rate);
    bus.ramp_en     = en;
    bus.target_duty = 8'(tgt);
    bus.step_size   = 8'(step);
    bus.rate_div    = 16'(rate);
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input int duty, input logic busy, input logic done);
    check({name, ".duty"}, 32'(bus.duty_out), 32'(duty));
    check({name, ".busy"}, 32'(bus.busy), 32'(busy));
    check({name, ".done"}, 32'(bus.done_pulse), 32'(done));
  endtask

  // Behavioural model: direction sign, cycles spent in the current phase.
  int m_duty, m_dir, m_wait;
  logic m_done;

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : (v < 0) ? -1 : 0;
  endfunction

  task automatic model_step();
    int tgt, stp, rate, s;
    tgt  = int'(bus.target_duty);
    stp  = int'(bus.step_size);
    rate = int'(bus.rate_div);
    m_done = 1'b0;
    if (!bus.ramp_en) begin
      m_duty = tgt; m_dir = 0; m_wait = 0;
    end else if (m_dir == 0) begin
      m_dir = sgn(tgt - m_duty); m_wait = 0;
    end else begin
      s = sgn(tgt - m_duty);
      if (s != m_dir) begin
        m_dir = s; m_wait = 0;
      end else if (m_wait >= rate) begin
        m_wait = 0;
        if (stp == 0)       m_duty = tgt;
        else if (m_dir > 0) m_duty = (m_duty + stp > tgt) ? tgt : m_duty + stp;
        else                m_duty = (m_duty - stp < tgt) ? tgt : m_duty - stp;
        if (m_duty == tgt) begin m_dir = 0; m_done = 1'b1; end
      end else begin
        m_wait++;
      end
    end
  endtask

  initial begin
    int exp_rev[5];
    int ndone;
    bus.tri_mode = 1'b0;

    // Reset held with a pending target: outputs stay at reset values.
    drive(1'b1, 200, 16, 0);
    cyc(3);
    check_out("reset_hold", 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1);
    check_out("reset_release_up", 0, 1'b1, 1'b0);
    cyc(1);
    check_out("reset_release_step", 16, 1'b1, 1'b0);

    // Directed vectors: basic ramp, saturation both ways, zero step.
    vecs.push_back(vec_t'{1'b0,   0, 16, 3, 1,   0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1,  64, 16, 3, 1,   0, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b1,  64, 16, 3, 3,   0, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b1,  64, 16, 3, 1,  16, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b1,  64, 16, 3, 4,  32, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b1,  64, 16, 3, 4,  48, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b1,  64, 16, 3, 3,  48, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b1,  64, 16, 3, 1,  64, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1,  64, 16, 3, 1,  64, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 250, 16, 0, 1, 250, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1, 255, 16, 0, 1, 250, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b1, 255, 16, 0, 1, 255, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0,  10, 16, 0, 1,  10, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1,   0, 16, 0, 1,  10, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b1,   0, 16, 0, 1,   0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 200,  0, 2, 1,   0, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b1, 200,  0, 2, 2,   0, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b1, 200,  0, 2, 1, 200, 1'b0, 1'b1});
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].tgt, vecs[i].step, vecs[i].rate);
      cyc(vecs[i].ncyc);
      check_out($sformatf("vec%0d", i), vecs[i].duty, vecs[i].busy, vecs[i].done);
    end

    // Reversal mid-ramp: 0 -> 200, retarget to 40 at 96.
    drive(1'b0, 0, 16, 0); cyc(1);
    drive(1'b1, 200, 16, 0); cyc(7);
    check_out("rev_at96", 96, 1'b1, 1'b0);
    bus.target_duty = 8'd40;
    exp_rev = '{96, 80, 64, 48, 40};
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check($sformatf("rev_duty%0d", i), 32'(bus.duty_out), 32'(exp_rev[i]));
      ndone += int'(bus.done_pulse);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      ndone += int'(bus.done_pulse);
    end
    check("rev_done_count", 32'(ndone), 32'd1);
    check("rev_busy_end", 32'(bus.busy), 32'd0);

    // Abort by dropping ramp_en at 48.
    drive(1'b0, 0, 16, 0); cyc(1);
    drive(1'b1, 200, 16, 0); cyc(4);
    check_out("abort_at48", 48, 1'b1, 1'b0);
    bus.ramp_en = 1'b0;
    cyc(1);
    check_out("abort_bypass", 200, 1'b0, 1'b0);
    bus.ramp_en = 1'b1;
    cyc(2);
    check_out("abort_stays_idle", 200, 1'b0, 1'b0);

    // Asynchronous reset mid-ramp; ramp restarts from zero afterwards.
    drive(1'b0, 0, 16, 0); cyc(1);
    drive(1'b1, 200, 16, 0); cyc(3);
    check_out("arst_pre", 32, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_out("arst_async", 0, 1'b0, 1'b0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    check_out("arst_restart", 0, 1'b1, 1'b0);
    cyc(1);
    check_out("arst_first_step", 16, 1'b1, 1'b0);

`ifdef PWM_RAMP_TRIANGLE_EN
    begin
      int exp_tri_d[6];
      logic exp_tri_p[6];
      exp_tri_d = '{16, 32, 16, 0, 16, 32};
      exp_tri_p = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      drive(1'b0, 0, 16, 0); cyc(1);
      bus.tri_mode = 1'b1;
      drive(1'b1, 32, 16, 0); cyc(1);
      for (int i = 0; i < 6; i++) begin
        if (i == 5) bus.tri_mode = 1'b0;
        cyc(1);
        check_out($sformatf("tri%0d", i), exp_tri_d[i], (i == 5) ? 1'b0 : 1'b1, exp_tri_p[i]);
      end
      cyc(1);
      check_out("tri_stopped", 32, 1'b0, 1'b0);
    end
`endif

    // Randomized run against the behavioural model, starting from reset.
    #2 rst_n = 1'b0;
    drive(1'b1, 0, 8, 1);
    cyc(1);
    rst_n = 1'b1;
    m_duty = 0; m_dir = 0; m_wait = 0; m_done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check("rnd.duty", 32'(bus.duty_out), 32'(m_duty));
      check("rnd.busy", 32'(bus.busy), 32'(m_dir != 0));
      check("rnd.done", 32'(bus.done_pulse), 32'(m_done));
      bus.ramp_en = ($urandom_range(0, 40) != 0);
      if ($urandom_range(0, 15) == 0) bus.target_duty = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) bus.step_size   = 8'($urandom_range(0, 40));
      if ($urandom_range(0, 31) == 0) bus.rate_div    = 16'($urandom_range(0, 5));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_sequencer.md
Name: pwm_ramp_sequencer

Overview:
- Sequences the PWM duty-cycle register: ramps the applied duty from its current value toward an SPI-written target in programmable steps at a programmable rate.
- Sits between the SPI register bank (target/step/rate/enable inputs) and the PWM peripheral's duty-cycle input.
- Gives soft-start/fade on all PWM-enabled outputs; bypass mode passes the target straight through.

Parameters:
- DUTY_W, 8, width of duty, target and step values.
- PRESC_W, 16, width of rate divider and prescaler counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- ramp_en  input  1  1 = ramp mode, 0 = bypass (duty follows target).
- target_duty  input  DUTY_W  requested duty cycle from register bank.
- step_size  input  DUTY_W  duty increment/decrement per tick; 0 = jump to target on next tick.
- rate_div  input  PRESC_W  one tick every rate_div+1 clk cycles.
- tri_mode  input  1  triangle-mode request; ignored unless PWM_RAMP_TRIANGLE_EN is defined.
- duty_out  output  DUTY_W  applied duty cycle to PWM peripheral.
- busy  output  1  high while state is UP or DOWN.
- done_pulse  output  1  one-cycle pulse when a ramp lands on target.

Behaviour:
- Async reset: state=IDLE, duty_out=0, busy=0, done_pulse=0, prescaler=0. All outputs registered.
- States: IDLE, UP, DOWN. busy is registered and equals (state != IDLE).
- Prescaler: cleared in IDLE and on any state change. Otherwise increments each cycle. tick=1 when count >= rate_div, then count wraps to 0. Using >= means a mid-ramp decrease of rate_div ticks on the next cycle.
- First step lands rate_div+1 cycles after entering UP/DOWN. Later steps land every rate_div+1 cycles.
- IDLE: if ramp_en and target_duty > duty_out, go to UP; if target_duty < duty_out, go to DOWN; otherwise stay.
- UP, on tick:
  - Compute duty_out+step in DUTY_W+1 bits, then clamp: duty_out = min(sum, target_duty).
  - No wrap past 2^DUTY_W-1.
- DOWN, on tick:
  - If duty_out < step_size, the difference floors at 0.
  - duty_out = max(difference, target_duty). No underflow.
- step_size=0: duty_out = target_duty on the tick.
- Arrival: the cycle duty_out becomes equal to target_duty, state returns to IDLE and done_pulse=1 for exactly that cycle.
- target_duty is sampled every cycle:
  - If it crosses to the other side of duty_out during UP/DOWN, the direction flips on the next cycle and the prescaler restarts.
  - If it becomes equal to duty_out without a step, go to IDLE with no done_pulse.
- ramp_en=0, at any time:
  - Next cycle: duty_out=target_duty, state=IDLE, busy=0, prescaler=0, done_pulse=0.
  - An ongoing ramp aborts with no pulse.
- Changes to step_size and rate_div take effect on the next tick. No shadow registers.
- Async reset mid-ramp returns immediately to the reset values. The ramp does not resume.

Optional Feature:
- Macro: PWM_RAMP_TRIANGLE_EN.
- Defined:
  - With tri_mode=1 and ramp_en=1, arriving at target from UP enters DOWN toward 0.
  - Arriving at 0 enters UP toward target_duty. This repeats continuously.
  - done_pulse fires at each peak and trough. busy stays 1.
  - tri_mode=0 ends the pattern at the next arrival, then goes to IDLE.
- Undefined: tri_mode is unused; behaviour is exactly as above. The port remains so the top-level pinout is fixed.

Decomposition:
- Package pwm_ramp_pkg holds:
  - state enum (IDLE, UP, DOWN);
  - DUTY_W and PRESC_W default constants;
  - saturating add/sub helper functions.
- Sub-module pwm_ramp_prescaler: counter plus tick generation, with clear input and rate_div input.

Test Plan:
1. Reset: hold rst_n=0 with target=200, ramp_en=1 -> duty_out=0, busy=0, done_pulse=0. Release -> ramp starts toward 200.
2. Basic ramp: step=16, rate_div=3, target 0->64 -> duty_out 16, 32, 48, 64, one step every 4 cycles, first step 4 cycles after entering UP. done_pulse is a single cycle with duty_out=64. busy then drops.
3. Saturation: duty_out=250, target=255, step=16 -> duty_out=255 (no wrap to 10). Then duty_out=10, target=0, step=16 -> duty_out=0 (no wrap to 250).
4. Reversal: step=16 ramping 0->200, at duty_out=96 set target=40 -> state flips to DOWN. Next ticks give 80, 64, 48, 40. Exactly one done_pulse.
5. Abort/bypass: mid-ramp at 48, drop ramp_en with target=200 -> next cycle duty_out=200, busy=0, no done_pulse. Assert rst_n=0 mid-ramp -> duty_out=0 asynchronously.
6. With PWM_RAMP_TRIANGLE_EN: tri_mode=1, target=32, step=16, rate_div=0 -> duty_out sequence 16, 32, 16, 0, 16, 32, ... with done_pulse at 32 and at 0. Clear tri_mode -> stops at next arrival, IDLE.
